// File: rtl/wb_regfile.sv
// Writeback stage: result select, R0-R14 register file with three decode read ports.
// Optional define WB_BYPASS_EN makes same-cycle reads of the register being written return ResultW.
module wb_regfile_rdport #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 15
) (
    input  logic [3:0]                   addr,
    input  logic [NREGS-1:0][DATA_W-1:0] regs,
    input  logic [DATA_W-1:0]            pc8,
    input  logic [DATA_W-1:0]            result,
    input  logic                         byp_we,
    input  logic [3:0]                   waddr,
    output logic [DATA_W-1:0]            rd
);
    // R15 falls through to PC+8 and is never bypassed (waddr is never 15 while byp_we=1)
    always_comb begin
        rd = pc8;
        for (int i = 0; i < NREGS; i++)
            if (addr == 4'(i)) rd = regs[i];
        if (byp_we && addr == waddr && addr != 4'hF) rd = result;
    end
endmodule

module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteW,
    input  logic              MemtoRegW,
    input  logic              PCSrcW,
    input  logic              branchLinkW,
    input  logic [DATA_W-1:0] ReadDataW,
    input  logic [DATA_W-1:0] ALUOutW,
    input  logic [3:0]        WA3W,
    input  logic [DATA_W-1:0] PCPlus4W,
    input  logic [3:0]        A1,
    input  logic [3:0]        A2,
    input  logic [3:0]        A3,
    input  logic [DATA_W-1:0] PCPlus8D,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] RD3,
    output logic [DATA_W-1:0] ResultW,
    output logic              WBWeW,
    output logic [3:0]        WBAddrW,
    output logic              PCWriteW
);
    localparam int NRP = 3;

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [NRP-1:0][3:0]          raddr;
    logic [NRP-1:0][DATA_W-1:0]   rdata;
    logic                         byp_we;

    // BL forces the link write to R14 regardless of RegWriteW/WA3W; R15 writes only steer the PC
    assign ResultW  = branchLinkW ? PCPlus4W : (MemtoRegW ? ReadDataW : ALUOutW);
    assign WBAddrW  = branchLinkW ? 4'd14 : WA3W;
    assign WBWeW    = branchLinkW | (RegWriteW & (WA3W != 4'hF));
    assign PCWriteW = PCSrcW;

`ifdef WB_BYPASS_EN
    // reads must show cleared contents while reset is held
    assign byp_we = WBWeW & ~reset;
`else
    assign byp_we = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (WBWeW && WBAddrW == 4'(i)) regs[i] <= ResultW;
        end
    end

    assign raddr = {A3, A2, A1};
    assign RD1   = rdata[0];
    assign RD2   = rdata[1];
    assign RD3   = rdata[2];

    genvar p;
    generate
        for (p = 0; p < NRP; p++) begin : g_rp
            wb_regfile_rdport #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rp (
                .addr  (raddr[p]),
                .regs  (regs),
                .pc8   (PCPlus8D),
                .result(ResultW),
                .byp_we(byp_we),
                .waddr (WBAddrW),
                .rd    (rdata[p])
            );
        end
    endgenerate
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: vector table for writeback select/commit, scoreboard for committed writes.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteW, MemtoRegW, PCSrcW, branchLinkW;
    logic [31:0] ReadDataW, ALUOutW, PCPlus4W, PCPlus8D;
    logic [3:0]  WA3W, A1, A2, A3;
    logic [31:0] RD1, RD2, RD3, ResultW;
    logic        WBWeW, PCWriteW;
    logic [3:0]  WBAddrW;

    wb_regfile dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .PCSrcW(PCSrcW), .branchLinkW(branchLinkW), .ReadDataW(ReadDataW),
        .ALUOutW(ALUOutW), .WA3W(WA3W), .PCPlus4W(PCPlus4W), .A1(A1), .A2(A2),
        .A3(A3), .PCPlus8D(PCPlus8D), .RD1(RD1), .RD2(RD2), .RD3(RD3),
        .ResultW(ResultW), .WBWeW(WBWeW), .WBAddrW(WBAddrW), .PCWriteW(PCWriteW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, m2r, pcs, bl;
        logic [31:0] rdata, alu, pc4;
        logic [3:0]  wa;
        logic [31:0] e_res;
        logic        e_we;
        logic [3:0]  e_addr;
        logic        e_pcw;
    } vec_t;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    localparam int NV = 10;
    vec_t        tbl[NV];
    wr_t         sbq[$];
    wr_t         w;
    logic [31:0] mdl[15];
    logic [31:0] exp_rd;
    int          total = 0;
    int          bad = 0;

    function automatic vec_t mk(logic rw, logic m2r, logic pcs, logic bl, logic [31:0] rdata,
                                logic [31:0] alu, logic [31:0] pc4, logic [3:0] wa,
                                logic [31:0] e_res, logic e_we, logic [3:0] e_addr, logic e_pcw);
        vec_t v;
        v.rw = rw; v.m2r = m2r; v.pcs = pcs; v.bl = bl; v.rdata = rdata; v.alu = alu;
        v.pc4 = pc4; v.wa = wa; v.e_res = e_res; v.e_we = e_we; v.e_addr = e_addr; v.e_pcw = e_pcw;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        RegWriteW = 0; MemtoRegW = 0; PCSrcW = 0; branchLinkW = 0;
        ReadDataW = '0; ALUOutW = '0; PCPlus4W = '0; WA3W = '0;
    endtask

    task automatic sweep(string tag);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            A1 = 4'(i);
            #1;
            chk($sformatf("%s R%0d", tag, i), RD1, mdl[i]);
        end
    endtask

    initial begin
        // cols: rw m2r pcs bl rdata alu pc4 wa | res we addr pcw
        tbl[0] = mk(1,0,0,0, 32'h0,        32'hDEADBEEF, 32'h0,   4'd7,  32'hDEADBEEF, 1, 4'd7,  0);
        tbl[1] = mk(1,1,0,0, 32'hCAFEF00D, 32'h1,        32'h0,   4'd2,  32'hCAFEF00D, 1, 4'd2,  0);
        tbl[2] = mk(1,0,0,1, 32'h0,        32'h55,       32'h204, 4'd5,  32'h204,      1, 4'd14, 0);
        tbl[3] = mk(1,0,1,0, 32'h0,        32'h400,      32'h0,   4'd15, 32'h400,      0, 4'd15, 1);
        tbl[4] = mk(0,0,0,0, 32'h0,        32'h77,       32'h0,   4'd3,  32'h77,       0, 4'd3,  0);
        tbl[5] = mk(1,0,0,0, 32'h0,        32'h11,       32'h0,   4'd1,  32'h11,       1, 4'd1,  0);
        tbl[6] = mk(1,1,0,0, 32'h22,       32'h9,        32'h0,   4'd2,  32'h22,       1, 4'd2,  0);
        tbl[7] = mk(1,0,0,0, 32'h0,        32'h33,       32'h0,   4'd3,  32'h33,       1, 4'd3,  0);
        tbl[8] = mk(1,0,0,0, 32'h0,        32'hA5A5A5A5, 32'h0,   4'd0,  32'hA5A5A5A5, 1, 4'd0,  0);
        tbl[9] = mk(1,0,0,0, 32'h0,        32'h0E0E0E0E, 32'h0,   4'd14, 32'h0E0E0E0E, 1, 4'd14, 0);

        foreach (mdl[i]) mdl[i] = '0;
        idle();
        PCPlus8D = 32'h108;
        A1 = 0; A2 = 0; A3 = 15;
        reset = 1;
        #2;
        chk("reset RD1 R0", RD1, 32'h0);
        chk("reset RD3 R15", RD3, 32'h108);
        @(negedge clk);
        reset = 0;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            RegWriteW = tbl[k].rw; MemtoRegW = tbl[k].m2r; PCSrcW = tbl[k].pcs;
            branchLinkW = tbl[k].bl; ReadDataW = tbl[k].rdata; ALUOutW = tbl[k].alu;
            PCPlus4W = tbl[k].pc4; WA3W = tbl[k].wa; A2 = tbl[k].e_addr;
            if (tbl[k].e_we) sbq.push_back('{a: tbl[k].e_addr, d: tbl[k].e_res});
            #1;
            chk($sformatf("v%0d ResultW", k), ResultW, tbl[k].e_res);
            chk($sformatf("v%0d WBWeW", k), 32'(WBWeW), 32'(tbl[k].e_we));
            chk($sformatf("v%0d WBAddrW", k), 32'(WBAddrW), 32'(tbl[k].e_addr));
            chk($sformatf("v%0d PCWriteW", k), 32'(PCWriteW), 32'(tbl[k].e_pcw));
            if (tbl[k].e_addr == 4'hF) exp_rd = PCPlus8D;
            else exp_rd = mdl[tbl[k].e_addr];
`ifdef WB_BYPASS_EN
            if (tbl[k].e_we) exp_rd = tbl[k].e_res;
`endif
            chk($sformatf("v%0d same-cycle RD2", k), RD2, exp_rd);
            @(posedge clk);
            #1;
            idle();
            if (sbq.size() != 0) begin
                w = sbq.pop_front();
                mdl[w.a] = w.d;
                A3 = w.a;
                #1;
                chk($sformatf("v%0d commit RD3", k), RD3, w.d);
            end
            sweep($sformatf("v%0d", k));
        end
        chk("queue drained", 32'(sbq.size()), 32'd0);

        // three independent ports, then all on one address
        @(negedge clk);
        A1 = 1; A2 = 2; A3 = 3;
        #1;
        chk("3port RD1", RD1, 32'h11);
        chk("3port RD2", RD2, 32'h22);
        chk("3port RD3", RD3, 32'h33);
        A1 = 2; A3 = 2;
        #1;
        chk("same RD1", RD1, 32'h22);
        chk("same RD2", RD2, 32'h22);
        chk("same RD3", RD3, 32'h22);

        // async reset between edges clears at once; a write under reset is discarded
        @(negedge clk);
        #2;
        reset = 1;
        A1 = 3;
        #1;
        chk("async reset RD1 R3", RD1, 32'h0);
        A1 = 15;
        #1;
        chk("reset RD1 R15", RD1, 32'h108);
        foreach (mdl[i]) mdl[i] = '0;
        RegWriteW = 1; WA3W = 4'd4; ALUOutW = 32'h99; A2 = 4;
        #1;
        chk("reset write-cycle RD2", RD2, 32'h0);
        @(posedge clk);
        #1;
        chk("write under reset dropped", RD2, 32'h0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        idle();
        mdl[4] = 32'h99;
        #1;
        chk("first write after reset", RD2, 32'h99);
        sweep("post-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage consumer of the memory-to-writeback pipeline register in the 32-bit ARM pipeline. It selects the writeback result, ReadData for loads, ALUOut for data processing, or PC+4 for branch-with-link. It commits that result into the architectural register file R0–R14 and serves the decode stage's three read ports. R15 reads return the decode-stage PC+8. The block also exports its write address, enable and data so the hazard unit can forward from writeback.

## Interface
Parameters:
- DATA_W, 32, register/data width
- NREGS, 15, number of stored registers (R0–R14)

Ports:
- clk  in  1  clock; all storage updates on rising edge
- reset  in  1  asynchronous, active-high; clears all stored registers
- RegWriteW  in  1  writeback of ALU/load result requested
- MemtoRegW  in  1  1 = result from ReadDataW, 0 = from ALUOutW
- PCSrcW  in  1  instruction in writeback redirects PC (passed through)
- branchLinkW  in  1  BL in writeback; write PCPlus4W to R14
- ReadDataW  in  32  load data
- ALUOutW  in  32  ALU result
- WA3W  in  4  destination register
- PCPlus4W  in  32  PC+4 of the writeback instruction
- A1, A2, A3  in  4 each  decode read addresses (A3 = store-data source)
- PCPlus8D  in  32  value returned for reads of R15
- RD1, RD2, RD3  out  32 each  read data
- ResultW  out  32  selected writeback value (fed to PC mux and forwarding)
- WBWeW  out  1  effective register-file write enable this cycle
- WBAddrW  out  4  effective write address this cycle
- PCWriteW  out  1  PCSrcW passed through; fetch loads ResultW into PC

## Operation
- Result select: ResultW = branchLinkW ? PCPlus4W : (MemtoRegW ? ReadDataW : ALUOutW).
- Effective write:
  - WBAddrW = branchLinkW ? 4'd14 : WA3W.
  - WBWeW = branchLinkW | (RegWriteW & (WA3W != 15)).
- A write to R15 (RegWriteW with WA3W=15) never touches storage. The PC update goes through PCWriteW/ResultW only.
- branchLinkW overrides RegWriteW and WA3W. At most one register is written per cycle.
- Storage: 15 × 32-bit registers, written on a rising clk edge when WBWeW=1.
- Reads are combinational:
  - Address 15 returns PCPlus8D.
  - Addresses 0–14 return stored contents, subject to the bypass rule in Configuration.
- All three read ports are independent. The same address on several ports returns the same value.
- No width conversion; all datapaths are full 32 bits.

## Timing
- Reset: asynchronous assert clears R0–R14 to 0 immediately, regardless of clk. While reset is held:
  - RD* return 0 for addresses 0–14 and PCPlus8D for 15.
  - No write occurs, even if WBWeW=1.
- Reset mid-operation: a write coincident with reset assertion is discarded. The first write after deassertion takes effect at the first rising edge with reset low.
- Output reset values:
  - RD1/2/3 = 0, or PCPlus8D for address 15.
  - ResultW, WBWeW, WBAddrW and PCWriteW are combinational from inputs and have no state.
- Write latency: the value is stored at the rising edge of the cycle in which WBWeW=1. From the next cycle it is visible on any read port without bypass.
- Same-cycle read of the address being written follows the WB_BYPASS_EN rule.
- Simultaneous branchLinkW=1 and RegWriteW=1 with WA3W=5: only R14 is written; R5 is unchanged.

## Configuration
- WB_BYPASS_EN defined:
  - A read port whose address equals WBAddrW while WBWeW=1 returns ResultW in the same cycle (write-before-read).
  - R15 is never bypassed.
- WB_BYPASS_EN undefined:
  - Same-cycle reads return the old stored value.
  - The hazard unit must forward from ResultW/WBAddrW/WBWeW or stall one cycle.

## Test plan
- Reset: write R3=0x1234 → assert reset between edges → RD1(A1=3) reads 0 immediately; A1=15 with PCPlus8D=0x108 → RD1=0x108.
- ALU writeback: RegWriteW=1, MemtoRegW=0, ALUOutW=0xDEADBEEF, WA3W=7 → after edge, RD2(A2=7)=0xDEADBEEF. In the write cycle, RD2 = new value with WB_BYPASS_EN, old value (0) without.
- Load writeback: MemtoRegW=1, ReadDataW=0xCAFEF00D, ALUOutW=0x1, WA3W=2 → ResultW=0xCAFEF00D; R2=0xCAFEF00D after edge.
- Branch-link: branchLinkW=1, RegWriteW=1, WA3W=5, PCPlus4W=0x204 → WBAddrW=14, WBWeW=1; R14=0x204 and R5 unchanged after edge.
- PC write: RegWriteW=1, WA3W=15, PCSrcW=1, ALUOutW=0x400 → WBWeW=0, PCWriteW=1, ResultW=0x400; R0–R14 all unchanged.
- Three ports: R1=0x11, R2=0x22, R3=0x33; A1=1, A2=2, A3=3 → RD1=0x11, RD2=0x22, RD3=0x33; then A1=A2=A3=2 → all read 0x22.
